// File: rtl/rep_upload_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rep_upload_arbiter_pkg
// Brief   : Ring node reply package. Holds the arbiter state encoding, flit
//           width, source index constants and a saturating counter helper.
// Revision: 1.0 - initial release
// ============================================================================
package rep_upload_arbiter_pkg;

  localparam int FLIT_W = 16;
  localparam int STAT_W = 16;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  localparam int SRC_DC  = 0;  // directory-controller reply upload
  localparam int SRC_MEM = 1;  // memory reply upload

  typedef enum logic {
    ST_IDLE  = ARB_IDLE,
    ST_GRANT = ARB_GRANT
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rep_upload_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rep_upload_arbiter_rr_pick
// Brief   : Combinational round-robin priority picker. Returns the first set
//           request bit scanning upward from (last_idx + 1) modulo NUM_SRC.
//           Shared with the request-side arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module rep_upload_arbiter_rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_idx,
  output logic [SRC_W-1:0]   o_winner,
  output logic               o_any
);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest rotational distance past last_idx
  always_comb begin
    w_best   = NUM_SRC;
    w_dist   = 0;
    o_winner = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_dist = (j + 2 * NUM_SRC - 1 - int'(i_last_idx)) % NUM_SRC;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = SRC_W'(j);
      end
    end
  end

  assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/rep_upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rep_upload_arbiter
// Brief   : Shares the ring node reply FIFO write port between NUM_SRC reply
//           upload units. Round-robin grant, held for a whole packet
//           (wormhole lock); the granted unit's flits are muxed to the FIFO.
//           Optional statistics counters: define REP_UPLOAD_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rep_upload_arbiter
  import rep_upload_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_upload_state,
  input  logic [FLIT_W*NUM_SRC-1:0] src_flit,
  input  logic [NUM_SRC-1:0]        v_src_flit,
  output logic [NUM_SRC-1:0]        src_fifo_rdy,
  input  logic                      rep_fifo_rdy,
  output logic [FLIT_W-1:0]         flit_out,
  output logic                      v_flit_out,
  output logic                      arb_busy,
  output logic [SRC_W-1:0]          grant_idx,
  output logic                      proto_err
`ifdef REP_UPLOAD_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]         pkt_cnt,
  output logic [STAT_W-1:0]         flit_cnt
`endif
);

  arb_state_e         r_state;
  logic [SRC_W-1:0]   r_grant_idx;
  logic [SRC_W-1:0]   r_last_idx;
  logic               r_proto_err;

  logic [SRC_W-1:0]   w_winner;
  logic               w_any;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic               w_sel_v;
  logic               w_sel_busy;
  logic               w_granted;
  logic               w_live;
  logic               w_foreign;

  rep_upload_arbiter_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .i_req      (src_upload_state),
    .i_last_idx (r_last_idx),
    .o_winner   (w_winner),
    .o_any      (w_any)
  );

  // Decode the held grant and select the granted unit's flit, valid and busy
  always_comb begin
    w_grant_oh = '0;
    w_sel_flit = '0;
    w_sel_v    = 1'b0;
    w_sel_busy = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (r_grant_idx == SRC_W'(j)) begin
        w_grant_oh[j] = 1'b1;
        w_sel_flit    = src_flit[FLIT_W*j +: FLIT_W];
        w_sel_v       = v_src_flit[j];
        w_sel_busy    = src_upload_state[j];
      end
    end
  end

  // The release cycle (granted unit no longer busy) passes nothing through
  assign w_granted = (r_state == ST_GRANT);
  assign w_live    = w_granted & w_sel_busy;
  assign w_foreign = w_granted ? |(v_src_flit & ~w_grant_oh) : |v_src_flit;

  // Port drive: everything reads zero while reset is asserted
  always_comb begin
    src_fifo_rdy = '0;
    flit_out     = '0;
    v_flit_out   = 1'b0;
    arb_busy     = 1'b0;
    grant_idx    = '0;
    proto_err    = 1'b0;
    if (!rst) begin
      src_fifo_rdy = w_grant_oh & {NUM_SRC{w_live & rep_fifo_rdy}};
      flit_out     = w_sel_flit;
      v_flit_out   = w_live & w_sel_v & rep_fifo_rdy;
      arb_busy     = w_granted;
      grant_idx    = r_grant_idx;
      proto_err    = r_proto_err;
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the grant until the owner goes idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= SRC_W'(SRC_DC);
      r_last_idx  <= SRC_W'(NUM_SRC - 1);
      r_proto_err <= 1'b0;
    end else begin
      if (w_foreign) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_GRANT;
            r_grant_idx <= w_winner;
            r_last_idx  <= w_winner;
          end
        end
        ST_GRANT: begin
          if (!w_sel_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef REP_UPLOAD_ARB_STATS_EN
  logic [STAT_W-1:0] r_pkt_cnt;
  logic [STAT_W-1:0] r_flit_cnt;

  // Saturating counts of granted packets and written flits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_pkt_cnt <= sat_inc(r_pkt_cnt);
      end
      if (v_flit_out) begin
        r_flit_cnt <= sat_inc(r_flit_cnt);
      end
    end
  end

  assign pkt_cnt  = rst ? '0 : r_pkt_cnt;
  assign flit_cnt = rst ? '0 : r_flit_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rep_upload_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_rep_upload_arbiter
// Brief   : Self-checking bench for rep_upload_arbiter (NUM_SRC = 2).
//           Optional counters checked when REP_UPLOAD_ARB_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rep_upload_arbiter;
  import rep_upload_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      busy;
  logic [N-1:0]      vsrc;
  logic [N-1:0]      srdy;
  logic [FLIT_W*N-1:0] sflit;
  logic              rdy;
  logic [15:0]       fout;
  logic              vout;
  logic              abusy;
  logic [SW-1:0]     gidx;
  logic              perr;
`ifdef REP_UPLOAD_ARB_STATS_EN
  logic [15:0]       pkt_cnt;
  logic [15:0]       flit_cnt;
`endif

  always #5 clk = ~clk;

  rep_upload_arbiter #(.NUM_SRC(N), .SRC_W(SW)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_upload_state (busy),
    .src_flit         (sflit),
    .v_src_flit       (vsrc),
    .src_fifo_rdy     (srdy),
    .rep_fifo_rdy     (rdy),
    .flit_out         (fout),
    .v_flit_out       (vout),
    .arb_busy         (abusy),
    .grant_idx        (gidx),
    .proto_err        (perr)
`ifdef REP_UPLOAD_ARB_STATS_EN
    ,
    .pkt_cnt          (pkt_cnt),
    .flit_cnt         (flit_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which unit owns the port (-1 = nobody), rotation pointer
  int   m_owner = -1;
  int   m_gidx  = 0;
  int   m_ptr   = N - 1;
  bit   m_err   = 1'b0;
  int   m_pkt   = 0;
  int   m_flit  = 0;

  logic [15:0]  got_q[$];
  int           gnt_q[$];
  bit           prev_busy = 1'b0;
  logic [N-1:0] acc;

  typedef struct {
    bit       rst;
    bit [1:0] busy;
    bit [1:0] v;
    bit       rdy;
    bit       e_busy;
    bit [1:0] e_g;
    bit       e_v;
    bit [1:0] e_rdy;
    bit       e_err;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare DUT outputs against the model mid-cycle, then log observations
  task automatic half_a();
    bit           live;
    logic [N-1:0] e_rdy;
    bit           e_v;
    @(negedge clk);
    live  = 1'b0;
    e_rdy = '0;
    e_v   = 1'b0;
    if (rst) begin
      chk("rst_arb_busy", 32'(abusy), 32'd0);
      chk("rst_grant",    32'(gidx),  32'd0);
      chk("rst_rdy",      32'(srdy),  32'd0);
      chk("rst_vout",     32'(vout),  32'd0);
      chk("rst_flit",     32'(fout),  32'd0);
      chk("rst_perr",     32'(perr),  32'd0);
    end else begin
      if (m_owner >= 0) live = busy[m_owner];
      if (live && rdy) e_rdy[m_owner] = 1'b1;
      if (live) e_v = vsrc[m_owner] && rdy;
      chk("arb_busy",  32'(abusy), 32'(m_owner >= 0));
      chk("grant_idx", 32'(gidx),  32'(m_gidx));
      chk("src_rdy",   32'(srdy),  32'(e_rdy));
      chk("v_flit",    32'(vout),  32'(e_v));
      if (e_v) chk("flit_out", 32'(fout), 32'(sflit[16*m_owner +: 16]));
      chk("proto_err", 32'(perr),  32'(m_err));
    end
`ifdef REP_UPLOAD_ARB_STATS_EN
    chk("pkt_cnt",  32'(pkt_cnt),  rst ? 32'd0 : 32'(m_pkt));
    chk("flit_cnt", 32'(flit_cnt), rst ? 32'd0 : 32'(m_flit));
`endif
    acc = srdy & vsrc;
    if (vout) got_q.push_back(fout);
    if (abusy && !prev_busy) gnt_q.push_back(int'(gidx));
    prev_busy = abusy;
  endtask

  // Advance the model across the clock edge using this cycle's inputs
  task automatic half_b();
    int nx_owner;
    int nx_ptr;
    int nx_g;
    bit nx_err;
    int nx_pkt;
    int nx_flit;
    nx_owner = m_owner; nx_ptr = m_ptr; nx_g = m_gidx;
    nx_err = m_err; nx_pkt = m_pkt; nx_flit = m_flit;
    if (rst) begin
      nx_owner = -1; nx_ptr = N - 1; nx_g = 0; nx_err = 1'b0; nx_pkt = 0; nx_flit = 0;
    end else begin
      for (int j = 0; j < N; j++)
        if (vsrc[j] && (j != m_owner)) nx_err = 1'b1;
      if (m_owner >= 0) begin
        if (busy[m_owner] && vsrc[m_owner] && rdy && (nx_flit < 65535)) nx_flit++;
        if (!busy[m_owner]) nx_owner = -1;
      end else begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (m_ptr + off) % N;
          if (busy[c] && (nx_owner < 0)) begin
            nx_owner = c; nx_ptr = c; nx_g = c;
          end
        end
        if ((nx_owner >= 0) && (nx_pkt < 65535)) nx_pkt++;
      end
    end
    @(posedge clk);
    m_owner = nx_owner; m_ptr = nx_ptr; m_gidx = nx_g;
    m_err = nx_err; m_pkt = nx_pkt; m_flit = nx_flit;
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = '0; vsrc = '0; rdy = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One upload unit sending flits of pkt (MSB flit first); returns after
  // `stop` accepted flits with busy still high
  task automatic send_pkt(input int u, input int n, input int stop, input bit bp,
                          input logic [175:0] pkt, output int cyc);
    int k;
    k = 0;
    cyc = 0;
    got_q.delete();
    busy[u] = 1'b1;
    while ((k < stop) && (cyc < 300)) begin
      vsrc    = '0;
      vsrc[u] = abusy && (int'(gidx) == u);
      sflit[16*u +: 16] = pkt[16*(n-1-k) +: 16];
      rdy = bp ? ((cyc % 3) == 0) : 1'b1;
      half_a();
      half_b();
      if (acc[u]) k++;
      cyc++;
    end
    vsrc = '0;
    rdy  = 1'b1;
    chk("pkt_flits_sent", 32'(k), 32'(stop));
  endtask

  task automatic finish_pkt(input int u, input int n, input logic [175:0] pkt);
    busy[u] = 1'b0;
    half_a();
    chk("release_hold", 32'(abusy), 32'd1);
    half_b();
    half_a();
    chk("release_drop", 32'(abusy), 32'd0);
    half_b();
    chk("flit_count", 32'(got_q.size()), 32'(n));
    for (int k = 0; k < got_q.size() && k < n; k++)
      chk("flit_order", 32'(got_q[k]), 32'(pkt[16*(n-1-k) +: 16]));
  endtask

  // Free-running upload units; plen > 0 fixes the packet length
  task automatic run_units(input int cycles, input bit want_all, input bit rnd_rdy,
                           input bit bad, input int plen);
    int rem[N];
    bit drop[N];
    for (int j = 0; j < N; j++) begin rem[j] = 0; drop[j] = 1'b0; end
    for (int c = 0; c < cycles; c++) begin
      for (int j = 0; j < N; j++) begin
        if (drop[j]) begin
          busy[j] = 1'b0; drop[j] = 1'b0;
        end else if (!busy[j] && (want_all || ($urandom_range(3) == 0))) begin
          busy[j] = 1'b1;
          rem[j]  = (plen > 0) ? plen : int'($urandom_range(6, 1));
        end
        vsrc[j] = busy[j] && (rem[j] > 0) && abusy && (int'(gidx) == j);
        if (bad && ($urandom_range(7) == 0)) vsrc[j] = 1'b1;
        sflit[16*j +: 16] = 16'($urandom);
      end
      rdy = rnd_rdy ? ($urandom_range(2) != 0) : 1'b1;
      half_a();
      half_b();
      for (int j = 0; j < N; j++)
        if (acc[j] && (rem[j] > 0)) begin
          rem[j]--;
          if (rem[j] == 0) drop[j] = 1'b1;
        end
    end
    busy = '0; vsrc = '0; rdy = 1'b1;
    tick();
    tick();
  endtask

  logic [175:0] pkt;
  int           cyc;

  initial begin
    rst = 1'b1; busy = '0; vsrc = '0; rdy = 1'b1; sflit = '0;
    @(posedge clk); #1;

    // rst, busy, v, rdy | arb_busy, grant, v_out, src_rdy, proto_err
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 2'b01, 1'b1, 1'b1, 2'd0, 1'b1, 2'b01, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 2'b11, 2'b01, 1'b1, 1'b1, 2'd0, 1'b1, 2'b01, 1'b0};
    tbl[5]  = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0};
    tbl[9]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'd1, 1'b0, 2'b00, 1'b1};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 2'b00, 1'b1};
    tbl[11] = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 2'd0, 1'b1, 2'b01, 1'b1};
    tbl[12] = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[14] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[15] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0};
    tbl[16] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'd1, 1'b0, 2'b00, 1'b0};
    tbl[17] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 2'b00, 1'b0};
    tbl[18] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'd1, 1'b1, 2'b10, 1'b0};
    tbl[19] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'd1, 1'b0, 2'b00, 1'b0};
    tbl[20] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 2'b00, 1'b0};

    for (int i = 0; i < 21; i++) begin
      rst   = tbl[i].rst;
      busy  = tbl[i].busy;
      vsrc  = tbl[i].v;
      rdy   = tbl[i].rdy;
      sflit = {16'h2000 + 16'(i), 16'h1000 + 16'(i)};
      half_a();
      chk("tbl_arb_busy",  32'(abusy), 32'(tbl[i].e_busy));
      chk("tbl_grant",     32'(gidx),  32'(tbl[i].e_g));
      chk("tbl_vout",      32'(vout),  32'(tbl[i].e_v));
      chk("tbl_src_rdy",   32'(srdy),  32'(tbl[i].e_rdy));
      chk("tbl_proto_err", 32'(perr),  32'(tbl[i].e_err));
      if (tbl[i].e_v)
        chk("tbl_flit", 32'(fout),
            (tbl[i].e_g == 2'd0) ? 32'(16'h1000 + 16'(i)) : 32'(16'h2000 + 16'(i)));
      half_b();
    end

    // Single source, 11-flit packet with the FIFO always ready
    do_reset();
    for (int k = 0; k < 11; k++) pkt[16*k +: 16] = 16'($urandom);
    send_pkt(SRC_DC, 11, 11, 1'b0, pkt, cyc);
    chk("single_cycles", 32'(cyc), 32'd12);
    finish_pkt(SRC_DC, 11, pkt);

    // Back-pressure: FIFO ready pattern 1,0,0 repeating
    do_reset();
    for (int k = 0; k < 11; k++) pkt[16*k +: 16] = 16'($urandom);
    send_pkt(SRC_DC, 11, 11, 1'b1, pkt, cyc);
    finish_pkt(SRC_DC, 11, pkt);

    // Fairness: both units continuously busy
    do_reset();
    gnt_q.delete();
    run_units(60, 1'b1, 1'b0, 1'b0, 3);
    chk("fair_grants", 32'(gnt_q.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < gnt_q.size(); k++)
      chk("fair_order", 32'(gnt_q[k]), 32'((k % 2 == 0) ? SRC_DC : SRC_MEM));

    // Reset after 3 of 5 flits, then check the pointer restarted
    do_reset();
    for (int k = 0; k < 5; k++) pkt[16*k +: 16] = 16'($urandom);
    send_pkt(SRC_DC, 5, 3, 1'b0, pkt, cyc);
    chk("abort_flits", 32'(got_q.size()), 32'd3);
    rst = 1'b1; vsrc[0] = 1'b1;
    tick();
    rst = 1'b0; busy = '0; vsrc = '0;
    half_a();
    chk("post_rst_busy", 32'(abusy), 32'd0);
    chk("post_rst_vout", 32'(vout),  32'd0);
`ifdef REP_UPLOAD_ARB_STATS_EN
    chk("post_rst_pkt",  32'(pkt_cnt),  32'd0);
    chk("post_rst_flit", 32'(flit_cnt), 32'd0);
`endif
    half_b();
    busy = 2'b11;
    tick();
    half_a();
    chk("post_rst_ptr", 32'(gidx), 32'(SRC_DC));
    half_b();
    busy = '0;
    tick();
    tick();

    // Randomized traffic, well-behaved units
    do_reset();
    run_units(1500, 1'b0, 1'b1, 1'b0, 0);
    chk("clean_no_err", 32'(perr), 32'd0);

    // Randomized traffic with stray valids from non-granted units
    run_units(800, 1'b0, 1'b1, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
